// File: rtl/graph_pkg.sv
// Shared graph-engine definitions: datapath widths, HBM address bases, control
// encodings and the job word layout common to the MPU and the MGU.
package graph_pkg;

    localparam int VPropWidth   = 32;
    localparam int EIndexWidth  = 32;
    localparam int EDegreeWidth = 32;
    localparam int AddrWidth    = 33;
    localparam int DataWidth    = 256;
    localparam int UpdateWidth  = AddrWidth + VPropWidth;

    localparam logic [AddrWidth-1:0] EdgeBase   = 33'h1_0000_0000;
    localparam logic [AddrWidth-1:0] VertexBase = 33'h0_0000_0000;

    localparam logic [1:0] CTRL_BFS = 2'b10;

    localparam int VERTEX_BYTES = 32;
    localparam int EDGE_BYTES   = 4;
    localparam int LINE_BYTES   = 32;

    localparam int VertexShift    = $clog2(VERTEX_BYTES);
    localparam int EdgeShift      = $clog2(EDGE_BYTES);
    localparam int LineShift      = $clog2(LINE_BYTES);
    localparam int EntryWidth     = 8 * EDGE_BYTES;
    localparam int EntriesPerLine = DataWidth / EntryWidth;
    localparam int OffsetWidth    = $clog2(EntriesPerLine);

    // Job word: {ignored MSB, prop, edge index, edge degree}, degree in the LSBs
    localparam int JobDegLsb  = 0;
    localparam int JobIdxLsb  = JobDegLsb + EDegreeWidth;
    localparam int JobPropLsb = JobIdxLsb + EIndexWidth;
    localparam int JobWidth   = JobPropLsb + VPropWidth + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        EMIT,
        ACK_HI,
        ACK_LO
    } mgu_state_e;

    // BFS level increment that saturates so "unreached" (all ones) stays put
    function automatic logic [VPropWidth-1:0] sat_inc(input logic [VPropWidth-1:0] v);
        return (&v) ? v : v + VPropWidth'(1);
    endfunction

endpackage

// File: rtl/mgu_msg_build.sv
// Builds one update message from the buffered edge line: selects the edge entry,
// turns the destination id into a vertex byte address and increments the level.
module mgu_msg_build
    import graph_pkg::*;
(
    input  logic [DataWidth-1:0]   line_data_i,
    input  logic [OffsetWidth-1:0] offset_i,
    input  logic [VPropWidth-1:0]  prop_i,
    output logic [UpdateWidth-1:0] update_o
);

    logic [EntryWidth-1:0] dst;
    logic [AddrWidth-1:0]  dst_addr;

    always_comb begin
        dst = '0;
        for (int k = 0; k < EntriesPerLine; k++) begin
            if (offset_i == OffsetWidth'(k)) begin
                dst = line_data_i[k*EntryWidth +: EntryWidth];
            end
        end
        // Vertex records are 32 B apart; high id bits fall off the address width
        dst_addr = VertexBase + (AddrWidth'(dst) << VertexShift);
        update_o = {dst_addr, sat_inc(prop_i)};
    end

endmodule

// File: rtl/mgu_edge_scatter.sv
// Message generation unit: turns each activated BFS vertex into one update
// message per out-edge by streaming its edge list from HBM one line at a time.
module mgu_edge_scatter
    import graph_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [1:0]             control,
    input  logic [JobWidth-1:0]    job_data,
    input  logic                   job_ready,
    output logic                   job_resp,
    output logic [AddrWidth-1:0]   read_addr,
    output logic                   start_rd,
    input  logic                   end_rd,
    input  logic [DataWidth-1:0]   read_data,
    output logic [UpdateWidth-1:0] update,
    output logic                   update_ready,
    input  logic                   update_resp
);

    mgu_state_e              state_q, state_d;
    logic [VPropWidth-1:0]   prop_q, prop_d;
    logic [EDegreeWidth-1:0] remaining_q, remaining_d;
    logic [OffsetWidth-1:0]  offset_q, offset_d;
    logic [AddrWidth-1:0]    line_q, line_d;
    logic [DataWidth-1:0]    line_data_q, line_data_d;
    logic                    job_resp_q, job_resp_d;
    logic                    start_rd_q, start_rd_d;
    logic [AddrWidth-1:0]    read_addr_q, read_addr_d;
    logic [UpdateWidth-1:0]  update_q, update_d;
    logic                    update_ready_q, update_ready_d;

    logic [EDegreeWidth-1:0] job_deg;
    logic [EIndexWidth-1:0]  job_idx;
    logic [VPropWidth-1:0]   job_prop;
    logic [AddrWidth-1:0]    edge_byte;
    logic [UpdateWidth-1:0]  built_msg;
    logic                    unused_job_msb;

    assign job_deg        = job_data[JobDegLsb +: EDegreeWidth];
    assign job_idx        = job_data[JobIdxLsb +: EIndexWidth];
    assign job_prop       = job_data[JobPropLsb +: VPropWidth];
    assign unused_job_msb = job_data[JobWidth-1];
    assign edge_byte      = EdgeBase + (AddrWidth'(job_idx) << EdgeShift);

    mgu_msg_build u_msg_build (
        .line_data_i (line_data_q),
        .offset_i    (offset_q),
        .prop_i      (prop_q),
        .update_o    (built_msg)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            prop_q         <= '0;
            remaining_q    <= '0;
            offset_q       <= '0;
            line_q         <= '0;
            line_data_q    <= '0;
            job_resp_q     <= 1'b0;
            start_rd_q     <= 1'b0;
            read_addr_q    <= '0;
            update_q       <= '0;
            update_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prop_q         <= prop_d;
            remaining_q    <= remaining_d;
            offset_q       <= offset_d;
            line_q         <= line_d;
            line_data_q    <= line_data_d;
            job_resp_q     <= job_resp_d;
            start_rd_q     <= start_rd_d;
            read_addr_q    <= read_addr_d;
            update_q       <= update_d;
            update_ready_q <= update_ready_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        prop_d         = prop_q;
        remaining_d    = remaining_q;
        offset_d       = offset_q;
        line_d         = line_q;
        line_data_d    = line_data_q;
        job_resp_d     = 1'b0;
        start_rd_d     = 1'b0;
        read_addr_d    = read_addr_q;
        update_d       = update_q;
        update_ready_d = update_ready_q;

        case (state_q)
            IDLE: begin
                // The job_resp_q guard stops a still-held job_ready being taken twice
                if (job_ready && !job_resp_q) begin
                    job_resp_d  = 1'b1;
                    prop_d      = job_prop;
                    remaining_d = job_deg;
                    offset_d    = edge_byte[LineShift-1:EdgeShift];
                    line_d      = edge_byte & ~AddrWidth'(LINE_BYTES - 1);
                    if (job_deg != '0 && control == CTRL_BFS) begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                read_addr_d = line_q;
                start_rd_d  = 1'b1;
                state_d     = RD_WAIT;
            end
            RD_WAIT: begin
                if (end_rd) begin
                    line_data_d = read_data;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                update_d       = built_msg;
                update_ready_d = 1'b1;
                state_d        = ACK_HI;
            end
            ACK_HI: begin
                if (update_resp) begin
                    update_ready_d = 1'b0;
                    remaining_d    = remaining_q - EDegreeWidth'(1);
                    offset_d       = offset_q + OffsetWidth'(1);
                    state_d        = ACK_LO;
                end
            end
            ACK_LO: begin
                // Wait for the consumer to release its ack before the next message
                if (!update_resp) begin
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                    end else if (offset_q == '0) begin
                        line_d  = line_q + AddrWidth'(LINE_BYTES);
                        state_d = RD_REQ;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign job_resp     = job_resp_q;
    assign start_rd     = start_rd_q;
    assign read_addr    = read_addr_q;
    assign update       = update_q;
    assign update_ready = update_ready_q;

endmodule

// File: tb/tb_mgu_edge_scatter.sv
// Directed bench for mgu_edge_scatter: an HBM line responder, a 4-phase
// consumer and a bus monitor surround the DUT; expected messages are hand-derived.
module tb_mgu_edge_scatter;
    import graph_pkg::*;

    logic                   clk;
    logic                   resetn;
    logic [1:0]             control;
    logic [JobWidth-1:0]    jobData;
    logic                   jobReady;
    logic                   jobResp;
    logic [AddrWidth-1:0]   readAddr;
    logic                   startRd;
    logic                   endRd;
    logic [DataWidth-1:0]   readData;
    logic [UpdateWidth-1:0] update;
    logic                   updateReady;
    logic                   updateResp;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int jobDriveCyc = 0;
    int jobRespCount = 0;
    int violations = 0;
    int unstable = 0;
    int respHold = 1;
    int respLow = 0;
    logic consumerStall = 1'b0;

    logic [AddrWidth-1:0]   readLog[$];
    int                     startCycLog[$];
    int                     endRdLog[$];
    logic [UpdateWidth-1:0] msgLog[$];
    int                     urRiseLog[$];

    mgu_edge_scatter dut (
        .clk          (clk),
        .resetn       (resetn),
        .control      (control),
        .job_data     (jobData),
        .job_ready    (jobReady),
        .job_resp     (jobResp),
        .read_addr    (readAddr),
        .start_rd     (startRd),
        .end_rd       (endRd),
        .read_data    (readData),
        .update       (update),
        .update_ready (updateReady),
        .update_resp  (updateResp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge entry e holds destination id e+10, so line 0 carries ids 10..17
    function automatic logic [DataWidth-1:0] buildLine(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] e0;
        logic [DataWidth-1:0] l;
        e0 = (addr - EdgeBase) >> 2;
        l = '0;
        for (int k = 0; k < 8; k++) begin
            l[k*32 +: 32] = 32'(e0 + AddrWidth'(k) + AddrWidth'(10));
        end
        return l;
    endfunction

    function automatic logic [UpdateWidth-1:0] msgAt(input int i);
        if (i < msgLog.size()) return msgLog[i];
        return 'x;
    endfunction

    function automatic logic [AddrWidth-1:0] readAt(input int i);
        if (i < readLog.size()) return readLog[i];
        return 'x;
    endfunction

    function automatic int cycAt(input int q, input int i);
        if (q == 0) return (i < startCycLog.size()) ? startCycLog[i] : -1000;
        if (q == 1) return (i < endRdLog.size()) ? endRdLog[i] : -1000;
        return (i < urRiseLog.size()) ? urRiseLog[i] : -1000;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] prop, input logic [31:0] idx, input logic [31:0] deg,
                                 input logic [1:0] ctrl, input bit lateDrop);
        int n;
        @(negedge clk);
        control     = ctrl;
        jobData     = {1'b0, prop, idx, deg};
        jobReady    = 1'b1;
        jobDriveCyc = cyc;
        n = 0;
        while (!jobResp && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("job_resp_seen", 128'(jobResp), 128'(1));
        if (lateDrop) @(negedge clk);
        jobReady = 1'b0;
    endtask

    task automatic waitMsgs(input int target);
        int n;
        n = 0;
        while (msgLog.size() < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
    endtask

    // Bus monitor: samples just after each rising edge
    initial begin : monitor
        logic                   prevReady;
        logic [UpdateWidth-1:0] prevUpdate;
        prevReady  = 1'b0;
        prevUpdate = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (jobResp) jobRespCount++;
            if (updateReady && !prevReady) begin
                urRiseLog.push_back(cyc);
                if (updateResp) violations++;
            end
            if (updateReady && prevReady && update != prevUpdate) unstable++;
            prevReady  = updateReady;
            prevUpdate = update;
        end
    end

    // HBM responder: returns the requested line one cycle after start_rd
    initial begin : memory
        logic [AddrWidth-1:0] a;
        endRd    = 1'b0;
        readData = '0;
        forever begin
            @(negedge clk);
            if (startRd) begin
                a = readAddr;
                readLog.push_back(a);
                startCycLog.push_back(cyc);
                @(negedge clk);
                readData = buildLine(a);
                endRd    = 1'b1;
                endRdLog.push_back(cyc);
                @(negedge clk);
                endRd = 1'b0;
            end
        end
    end

    // Four-phase consumer: logs each message once, at the moment it acks it
    initial begin : consumer
        updateResp = 1'b0;
        forever begin
            @(negedge clk);
            if (updateReady && !updateResp && !consumerStall) begin
                msgLog.push_back(update);
                updateResp = 1'b1;
                repeat (respHold) @(negedge clk);
                for (int i = 0; i < 50 && updateReady; i++) @(negedge clk);
                updateResp = 1'b0;
                repeat (respLow) @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : main
        int rb, mb, ub, eb, jb, vb;
        resetn   = 1'b0;
        control  = 2'b00;
        jobData  = '0;
        jobReady = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_job_resp", 128'(jobResp), 128'(0));
        checkOutput("rst_start_rd", 128'(startRd), 128'(0));
        checkOutput("rst_read_addr", 128'(readAddr), 128'(0));
        checkOutput("rst_update", 128'(update), 128'(0));
        checkOutput("rst_update_ready", 128'(updateReady), 128'(0));
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] degree 0 job");
        rb = readLog.size(); ub = urRiseLog.size(); jb = jobRespCount;
        applyStimulus(32'd5, 32'd0, 32'd0, CTRL_BFS, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("deg0_resp_pulses", 128'(jobRespCount - jb), 128'(1));
        checkOutput("deg0_reads", 128'(readLog.size() - rb), 128'(0));
        checkOutput("deg0_updates", 128'(urRiseLog.size() - ub), 128'(0));

        $display("[TB] degree 3 from index 0");
        rb = readLog.size(); mb = msgLog.size(); ub = urRiseLog.size(); eb = endRdLog.size();
        applyStimulus(32'd7, 32'd0, 32'd3, CTRL_BFS, 1'b0);
        waitMsgs(mb + 3);
        checkOutput("deg3_reads", 128'(readLog.size() - rb), 128'(1));
        checkOutput("deg3_read_addr", 128'(readAt(rb)), 128'(33'h1_0000_0000));
        checkOutput("deg3_start_lat", 128'(cycAt(0, rb) - jobDriveCyc), 128'(2));
        checkOutput("deg3_update_lat", 128'(cycAt(2, ub) - cycAt(1, eb)), 128'(2));
        checkOutput("deg3_count", 128'(msgLog.size() - mb), 128'(3));
        checkOutput("deg3_msg0", 128'(msgAt(mb)), 128'({33'h140, 32'd8}));
        checkOutput("deg3_msg1", 128'(msgAt(mb + 1)), 128'({33'h160, 32'd8}));
        checkOutput("deg3_msg2", 128'(msgAt(mb + 2)), 128'({33'h180, 32'd8}));

        $display("[TB] index 6 degree 11 across three lines");
        rb = readLog.size(); mb = msgLog.size();
        applyStimulus(32'd100, 32'd6, 32'd11, CTRL_BFS, 1'b0);
        waitMsgs(mb + 11);
        checkOutput("idx6_reads", 128'(readLog.size() - rb), 128'(3));
        checkOutput("idx6_read0", 128'(readAt(rb)), 128'(33'h1_0000_0000));
        checkOutput("idx6_read1", 128'(readAt(rb + 1)), 128'(33'h1_0000_0020));
        checkOutput("idx6_read2", 128'(readAt(rb + 2)), 128'(33'h1_0000_0040));
        checkOutput("idx6_count", 128'(msgLog.size() - mb), 128'(11));
        for (int k = 0; k < 11; k++) begin
            // entries 6..16 hold ids 16..26, i.e. addresses 0x200..0x340
            checkOutput($sformatf("idx6_msg%0d", k), 128'(msgAt(mb + k)),
                        128'({33'h200 + 33'(32 * k), 32'd101}));
        end

        $display("[TB] saturating property");
        mb = msgLog.size();
        applyStimulus(32'hFFFF_FFFF, 32'd0, 32'd1, CTRL_BFS, 1'b0);
        waitMsgs(mb + 1);
        checkOutput("sat_count", 128'(msgLog.size() - mb), 128'(1));
        checkOutput("sat_msg", 128'(msgAt(mb)), 128'({33'h140, 32'hFFFF_FFFF}));

        $display("[TB] slow consumer handshake");
        mb = msgLog.size(); ub = urRiseLog.size(); vb = violations;
        respHold = 2;
        respLow  = 3;
        applyStimulus(32'd0, 32'd3, 32'd2, CTRL_BFS, 1'b0);
        waitMsgs(mb + 2);
        respHold = 1;
        respLow  = 0;
        checkOutput("hold_count", 128'(msgLog.size() - mb), 128'(2));
        checkOutput("hold_ready_rises", 128'(urRiseLog.size() - ub), 128'(2));
        checkOutput("hold_violations", 128'(violations - vb), 128'(0));
        checkOutput("hold_msg0", 128'(msgAt(mb)), 128'({33'h1A0, 32'd1}));
        checkOutput("hold_msg1", 128'(msgAt(mb + 1)), 128'({33'h1C0, 32'd1}));

        $display("[TB] edge line address wrap");
        rb = readLog.size(); mb = msgLog.size();
        applyStimulus(32'h10, 32'h3FFF_FFF8, 32'd9, CTRL_BFS, 1'b0);
        waitMsgs(mb + 9);
        checkOutput("wrap_reads", 128'(readLog.size() - rb), 128'(2));
        checkOutput("wrap_read0", 128'(readAt(rb)), 128'(33'h1_FFFF_FFE0));
        checkOutput("wrap_read1", 128'(readAt(rb + 1)), 128'(33'h0_0000_0000));
        for (int k = 0; k < 9; k++) begin
            checkOutput($sformatf("wrap_msg%0d", k), 128'(msgAt(mb + k)),
                        128'({33'h40 + 33'(32 * k), 32'h11}));
        end

        $display("[TB] non-BFS control");
        rb = readLog.size(); mb = msgLog.size(); jb = jobRespCount;
        applyStimulus(32'd9, 32'd0, 32'd4, 2'b01, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("ctrl01_resp_pulses", 128'(jobRespCount - jb), 128'(1));
        checkOutput("ctrl01_reads", 128'(readLog.size() - rb), 128'(0));
        checkOutput("ctrl01_msgs", 128'(msgLog.size() - mb), 128'(0));

        $display("[TB] reset while waiting for ack");
        consumerStall = 1'b1;
        mb = msgLog.size();
        applyStimulus(32'd1, 32'd0, 32'd5, CTRL_BFS, 1'b0);
        for (int i = 0; i < 50 && !updateReady; i++) @(negedge clk);
        checkOutput("abort_in_ack_hi", 128'(updateReady), 128'(1));
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("abort_job_resp", 128'(jobResp), 128'(0));
        checkOutput("abort_start_rd", 128'(startRd), 128'(0));
        checkOutput("abort_read_addr", 128'(readAddr), 128'(0));
        checkOutput("abort_update", 128'(update), 128'(0));
        checkOutput("abort_update_ready", 128'(updateReady), 128'(0));
        rb = readLog.size(); ub = urRiseLog.size();
        resetn = 1'b1;
        consumerStall = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("abort_no_reads", 128'(readLog.size() - rb), 128'(0));
        checkOutput("abort_no_ready", 128'(urRiseLog.size() - ub), 128'(0));
        checkOutput("abort_no_msgs", 128'(msgLog.size() - mb), 128'(0));

        $display("[TB] job after abort");
        mb = msgLog.size();
        applyStimulus(32'd2, 32'd1, 32'd1, CTRL_BFS, 1'b0);
        waitMsgs(mb + 1);
        checkOutput("post_count", 128'(msgLog.size() - mb), 128'(1));
        checkOutput("post_msg", 128'(msgAt(mb)), 128'({33'h160, 32'd3}));

        checkOutput("all_violations", 128'(violations), 128'(0));
        checkOutput("all_unstable", 128'(unstable), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
